// File: rtl/sdram_egress_arbiter.sv
// Egress arbiter between the per-port egress queues and the SDRAM command FSM.
// It picks a queue round-robin and pops that queue's address word. For a write it
// then pops the burst's data words from the same queue. The result is presented
// as one command plus a stream of write-data beats.
module sdram_egress_arbiter #(
  parameter int unsigned nr_of_wb_ports = 3,
  parameter int unsigned port_w         = 2
) (
  input  logic                        sdram_clk,
  input  logic                        sdram_rst,
  input  logic [35:0]                 fifo_q,
  input  logic [0:nr_of_wb_ports-1]   fifo_empty,
  output logic [0:nr_of_wb_ports-1]   fifo_re,
  output logic                        fifo_rd_adr,
  output logic                        fifo_rd_data,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [29:0]                 cmd_adr,
  output logic                        cmd_we,
  output logic [4:0]                  cmd_len,
  output logic [port_w-1:0]           cmd_port,
  output logic                        wdat_valid,
  input  logic                        wdat_ready,
  output logic [31:0]                 wdat,
  output logic [3:0]                  wdat_sel,
  output logic                        busy
);

  typedef enum logic [2:0] {StIdle, StAlat, StCap, StCmd, StWrd, StDlat, StDsnd} state_e;

  state_e              r_state, w_state_d;
  logic [port_w-1:0]   r_ptr, r_grant, r_cmd_port;
  logic [29:0]         r_cmd_adr;
  logic                r_cmd_we, r_cmd_valid, r_wdat_valid;
  logic [4:0]          r_cmd_len, r_beats;
  logic [31:0]         r_wdat;
  logic [3:0]          r_wdat_sel;

  logic [4:0]          w_len;
  logic                w_any;
  logic [port_w-1:0]   w_grant, w_idx, w_sel;

  assign cmd_valid  = r_cmd_valid;
  assign cmd_adr    = r_cmd_adr;
  assign cmd_we     = r_cmd_we;
  assign cmd_len    = r_cmd_len;
  assign cmd_port   = r_cmd_port;
  assign wdat_valid = r_wdat_valid;
  assign wdat       = r_wdat;
  assign wdat_sel   = r_wdat_sel;
  assign busy       = (r_state != StIdle);

  // Decode the burst length of the address word on fifo_q (only wrap bursts are > 1).
  always_comb begin
    w_len = 5'd1;
    if (fifo_q[2:0] == 3'b010) begin
      unique case (fifo_q[4:3])
        2'b01:   w_len = 5'd4;
        2'b10:   w_len = 5'd8;
        2'b11:   w_len = 5'd16;
        default: w_len = 5'd1;
      endcase
    end
  end

  // Round-robin search from r_ptr+1; scanning backwards lets the nearest queue win.
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_ptr;
    w_idx   = '0;
    for (int k = int'(nr_of_wb_ports); k >= 1; k--) begin
      w_idx = port_w'((int'(r_ptr) + k) % int'(nr_of_wb_ports));
      if (!fifo_empty[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Next state and FIFO read strobes; strobes are gated off while reset is high.
  always_comb begin
    w_state_d    = r_state;
    fifo_rd_adr  = 1'b0;
    fifo_rd_data = 1'b0;
    w_sel        = r_grant;
    fifo_re      = '0;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          fifo_rd_adr = 1'b1;
          w_sel       = w_grant;
          w_state_d   = StAlat;
        end
      end
      StAlat: w_state_d = StCap;
      StCap:  w_state_d = StCmd;
      StCmd: begin
        if (cmd_ready) w_state_d = r_cmd_we ? StWrd : StIdle;
      end
      StWrd: begin
        if (!fifo_empty[r_grant]) begin
          fifo_rd_data = 1'b1;
          w_state_d    = StDlat;
        end
      end
      StDlat: w_state_d = StDsnd;
      StDsnd: begin
        if (wdat_ready) w_state_d = (r_beats <= 5'd1) ? StIdle : StWrd;
      end
      default: w_state_d = StIdle;
    endcase
    if (sdram_rst) begin
      fifo_rd_adr  = 1'b0;
      fifo_rd_data = 1'b0;
      w_state_d    = StIdle;
    end
    for (int i = 0; i < int'(nr_of_wb_ports); i++) begin
      fifo_re[i] = (fifo_rd_adr | fifo_rd_data) & (w_sel == port_w'(i));
    end
  end

  // State, grant pointer, captured command and write-data registers.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      r_state      <= StIdle;
      r_ptr        <= port_w'(nr_of_wb_ports - 1);
      r_grant      <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_adr    <= '0;
      r_cmd_we     <= 1'b0;
      r_cmd_len    <= '0;
      r_cmd_port   <= '0;
      r_beats      <= '0;
      r_wdat_valid <= 1'b0;
      r_wdat       <= '0;
      r_wdat_sel   <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_ptr   <= w_grant;
            r_grant <= w_grant;
          end
        end
        StCap: begin
          r_cmd_adr   <= fifo_q[35:6];
          r_cmd_we    <= fifo_q[5];
          r_cmd_len   <= w_len;
          r_beats     <= w_len;
          r_cmd_port  <= r_grant;
          r_cmd_valid <= 1'b1;
        end
        StCmd: begin
          if (cmd_ready) r_cmd_valid <= 1'b0;
        end
        StDlat: begin
          r_wdat       <= fifo_q[35:4];
          r_wdat_sel   <= fifo_q[3:0];
          r_wdat_valid <= 1'b1;
        end
        StDsnd: begin
          if (wdat_ready) begin
            r_wdat_valid <= 1'b0;
            if (r_beats != 5'd0) r_beats <= r_beats - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_egress_arbiter.sv
// Scoreboard bench for sdram_egress_arbiter: a queue-based FIFO model feeds the DUT,
// expected commands/beats are queued by the stimulus and checked by a monitor.
module tb_sdram_egress_arbiter;

  typedef struct packed {
    logic [29:0] adr;
    logic        we;
    logic [4:0]  len;
    logic [1:0]  port;
  } cmd_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  sel;
  } wd_t;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst = 1'b1;
  logic [35:0] fifo_q = '0;
  logic [0:2]  fifo_empty = 3'b111;
  logic [0:2]  fifo_re;
  logic        fifo_rd_adr, fifo_rd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [29:0] cmd_adr;
  logic        cmd_we;
  logic [4:0]  cmd_len;
  logic [1:0]  cmd_port;
  logic        wdat_valid;
  logic        wdat_ready = 1'b1;
  logic [31:0] wdat;
  logic [3:0]  wdat_sel;
  logic        busy;

  always #5 sdram_clk = ~sdram_clk;

  sdram_egress_arbiter #(.nr_of_wb_ports(3), .port_w(2)) dut (
    .sdram_clk   (sdram_clk),
    .sdram_rst   (sdram_rst),
    .fifo_q      (fifo_q),
    .fifo_empty  (fifo_empty),
    .fifo_re     (fifo_re),
    .fifo_rd_adr (fifo_rd_adr),
    .fifo_rd_data(fifo_rd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_adr     (cmd_adr),
    .cmd_we      (cmd_we),
    .cmd_len     (cmd_len),
    .cmd_port    (cmd_port),
    .wdat_valid  (wdat_valid),
    .wdat_ready  (wdat_ready),
    .wdat        (wdat),
    .wdat_sel    (wdat_sel),
    .busy        (busy)
  );

  cmd_t        exp_cmd[$];
  wd_t         exp_wd[$];
  logic [35:0] q0[$], q1[$], q2[$];

  int   errors = 0, checks = 0;
  int   to_issued = 0, to_seen = 0;
  logic final_req = 1'b0, final_done = 1'b0;

  // ---------------- stimulus helpers ----------------
  function automatic logic [35:0] aw(input logic [29:0] a, input logic we,
                                     input logic [1:0] bte, input logic [2:0] cti);
    return {a, we, bte, cti};
  endfunction

  function automatic cmd_t mk_cmd(input logic [29:0] a, input logic we,
                                  input logic [4:0] len, input logic [1:0] p);
    cmd_t c;
    c.adr = a; c.we = we; c.len = len; c.port = p;
    return c;
  endfunction

  task automatic upd_empty();
    fifo_empty[0] = (q0.size() == 0);
    fifo_empty[1] = (q1.size() == 0);
    fifo_empty[2] = (q2.size() == 0);
  endtask

  task automatic push(input int p, input logic [35:0] w);
    case (p)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
    upd_empty();
  endtask

  task automatic push_data(input int p, input logic [31:0] d, input logic [3:0] s);
    wd_t e;
    e.d = d; e.sel = s;
    exp_wd.push_back(e);
    push(p, {d, s});
  endtask

  // One clock: sample strobes, then pop the model FIFO just after the edge.
  task automatic tick();
    logic sa, sd;
    logic [0:2] sr;
    @(negedge sdram_clk);
    sa = fifo_rd_adr; sd = fifo_rd_data; sr = fifo_re;
    @(posedge sdram_clk);
    #1;
    if (sa || sd) begin
      if (sr[0] && q0.size() > 0) fifo_q = q0.pop_front();
      if (sr[1] && q1.size() > 0) fifo_q = q1.pop_front();
      if (sr[2] && q2.size() > 0) fifo_q = q2.pop_front();
    end
    upd_empty();
  endtask

  function automatic bit is_idle();
    return !busy && exp_cmd.size() == 0 && exp_wd.size() == 0 &&
           q0.size() == 0 && q1.size() == 0 && q2.size() == 0;
  endfunction

  task automatic wait_idle(input int budget, input bit toggle);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (is_idle()) begin
        ok = 1'b1;
        break;
      end
      if (toggle) wdat_ready = ~wdat_ready;
      tick();
    end
    if (!ok) to_issued++;
    wdat_ready = 1'b1;
  endtask

  task automatic wait_wvalid(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wdat_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) to_issued++;
  endtask

  task automatic do_reset();
    sdram_rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    upd_empty();
    tick();
    sdram_rst = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Single read from queue 1.
    exp_cmd.push_back(mk_cmd(30'h100, 1'b0, 5'd1, 2'd1));
    push(1, aw(30'h100, 1'b0, 2'b00, 3'b000));
    wait_idle(100, 1'b0);

    // Wrap4 write from queue 0.
    exp_cmd.push_back(mk_cmd(30'h40, 1'b1, 5'd4, 2'd0));
    push(0, aw(30'h40, 1'b1, 2'b01, 3'b010));
    for (int i = 0; i < 4; i++) push_data(0, 32'hD000_0000 + 32'(i), 4'hF);
    wait_idle(200, 1'b0);

    // Round robin from reset, queue 0 refilled mid-sequence.
    do_reset();
    exp_cmd.push_back(mk_cmd(30'h200, 1'b0, 5'd1, 2'd0));
    exp_cmd.push_back(mk_cmd(30'h201, 1'b0, 5'd1, 2'd1));
    exp_cmd.push_back(mk_cmd(30'h202, 1'b0, 5'd1, 2'd2));
    push(0, aw(30'h200, 1'b0, 2'b00, 3'b000));
    push(1, aw(30'h201, 1'b0, 2'b11, 3'b111));
    push(2, aw(30'h202, 1'b0, 2'b00, 3'b010));
    repeat (6) tick();
    exp_cmd.push_back(mk_cmd(30'h203, 1'b0, 5'd1, 2'd0));
    push(0, aw(30'h203, 1'b0, 2'b00, 3'b001));
    wait_idle(200, 1'b0);

    // Backpressure: command stalled, then toggling wdat_ready.
    cmd_ready = 1'b0;
    exp_cmd.push_back(mk_cmd(30'h123456, 1'b1, 5'd4, 2'd1));
    push(1, aw(30'h123456, 1'b1, 2'b01, 3'b010));
    push_data(1, 32'hCAFE_0001, 4'h3);
    push_data(1, 32'hCAFE_0002, 4'hC);
    push_data(1, 32'hCAFE_0003, 4'h1);
    push_data(1, 32'hCAFE_0004, 4'h8);
    repeat (10) tick();
    cmd_ready = 1'b1;
    wait_idle(300, 1'b1);

    // Wrap8 write with the queue running dry after 3 data words.
    exp_cmd.push_back(mk_cmd(30'h3FF_0000, 1'b1, 5'd8, 2'd2));
    push(2, aw(30'h3FF_0000, 1'b1, 2'b10, 3'b010));
    for (int i = 0; i < 3; i++) push_data(2, 32'hA5A5_0000 + 32'(i), 4'(i + 1));
    repeat (30) tick();
    for (int i = 3; i < 8; i++) push_data(2, 32'hA5A5_0000 + 32'(i), 4'(i + 1));
    wait_idle(300, 1'b0);

    // Reset during the second beat of a wrap4 write.
    wdat_ready = 1'b0;
    exp_cmd.push_back(mk_cmd(30'h77, 1'b1, 5'd4, 2'd0));
    push(0, aw(30'h77, 1'b1, 2'b01, 3'b010));
    push_data(0, 32'h1111_0000, 4'hF);
    push(0, {32'h1111_0001, 4'hF});
    push(0, {32'h1111_0002, 4'hF});
    push(0, {32'h1111_0003, 4'hF});
    wait_wvalid(100);
    wdat_ready = 1'b1;
    tick();
    wdat_ready = 1'b0;
    wait_wvalid(100);
    do_reset();
    wdat_ready = 1'b1;
    exp_cmd.push_back(mk_cmd(30'h300, 1'b0, 5'd1, 2'd0));
    exp_cmd.push_back(mk_cmd(30'h301, 1'b0, 5'd1, 2'd1));
    push(1, aw(30'h301, 1'b0, 2'b00, 3'b000));
    push(0, aw(30'h300, 1'b0, 2'b00, 3'b000));
    wait_idle(200, 1'b0);

    // Wrap16 write.
    exp_cmd.push_back(mk_cmd(30'h500, 1'b1, 5'd16, 2'd2));
    push(2, aw(30'h500, 1'b1, 2'b11, 3'b010));
    for (int i = 0; i < 16; i++) push_data(2, 32'h0101_0101 * 32'(i + 1), 4'(i));
    wait_idle(300, 1'b0);

    final_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (final_done) break;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- monitor ----------------
  int          cyc = 0, adr_cyc = 0, data_pulses = 0;
  logic [1:0]  cur_port = '0;
  logic [4:0]  cur_len = '0;
  logic        cur_we = 1'b0;
  logic        pv_rst = 1'b0, pv_busy = 1'b0;
  logic        pv_cmd_valid = 1'b0, pv_cmd_ready = 1'b0;
  logic        pv_wdat_valid = 1'b0, pv_wdat_ready = 1'b0;
  logic [37:0] pv_cmd = '0;
  logic [35:0] pv_wd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare DUT outputs against the scoreboard and protocol rules, away from posedge.
  always @(negedge sdram_clk) begin
    logic [0:2] oh;
    cmd_t       ec;
    wd_t        ew;
    cyc++;
    if (sdram_rst) begin
      exp_cmd.delete();
      exp_wd.delete();
      cur_we      = 1'b0;
      data_pulses = 0;
    end else if (pv_rst) begin
      check("reset_ctl", {fifo_re, fifo_rd_adr, fifo_rd_data, cmd_valid, cmd_adr, cmd_we,
                          cmd_len, cmd_port, wdat_valid, busy}, '0);
      check("reset_data", {wdat, wdat_sel}, '0);
    end else begin
      oh = '0;
      oh[cur_port] = 1'b1;
      check("strobe_excl", 64'(fifo_rd_adr & fifo_rd_data), '0);
      if (!fifo_rd_adr && !fifo_rd_data) check("re_idle", 64'(fifo_re), '0);
      if (fifo_rd_adr) begin
        check("re_onehot_adr", $countones(fifo_re), 1);
        check("adr_on_empty", 64'(|(fifo_re & fifo_empty)), '0);
        adr_cyc = cyc;
      end
      if (fifo_rd_data) begin
        check("data_in_write", 64'(cur_we), 64'd1);
        check("re_data_port", 64'(fifo_re), 64'(oh));
        check("data_on_empty", 64'(|(fifo_re & fifo_empty)), '0);
        data_pulses++;
        check("data_pulse_le_len", 64'(data_pulses > int'(cur_len)), '0);
      end
      if (cmd_valid && !pv_cmd_valid) check("cmd_latency", cyc - adr_cyc, 3);
      if (pv_cmd_valid && !pv_cmd_ready)
        check("cmd_hold", {cmd_valid, cmd_adr, cmd_we, cmd_len, cmd_port}, {1'b1, pv_cmd});
      if (pv_wdat_valid && !pv_wdat_ready)
        check("wdat_hold", {wdat_valid, wdat, wdat_sel}, {1'b1, pv_wd});
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_unexpected", exp_cmd.size(), 1);
        end else begin
          ec = exp_cmd.pop_front();
          check("cmd", {cmd_adr, cmd_we, cmd_len, cmd_port}, 64'(ec));
          cur_port    = ec.port;
          cur_len     = ec.len;
          cur_we      = ec.we;
          data_pulses = 0;
        end
      end
      if (wdat_valid && wdat_ready) begin
        if (exp_wd.size() == 0) begin
          check("wdat_unexpected", exp_wd.size(), 1);
        end else begin
          ew = exp_wd.pop_front();
          check("wdat", {wdat, wdat_sel}, 64'(ew));
        end
      end
      if (pv_busy && !busy && cur_we) begin
        check("data_pulse_count", data_pulses, int'(cur_len));
        cur_we = 1'b0;
      end
    end
    if (to_issued != to_seen) begin
      check("timeout", to_seen, to_issued);
      to_seen = to_issued;
    end
    if (final_req && !final_done) begin
      check("cmd_left", exp_cmd.size(), 0);
      check("wdat_left", exp_wd.size(), 0);
      final_done = 1'b1;
    end
    pv_rst        = sdram_rst;
    pv_busy       = busy;
    pv_cmd_valid  = cmd_valid;
    pv_cmd_ready  = cmd_ready;
    pv_wdat_valid = wdat_valid;
    pv_wdat_ready = wdat_ready;
    pv_cmd        = {cmd_adr, cmd_we, cmd_len, cmd_port};
    pv_wd         = {wdat, wdat_sel};
  end

endmodule
